// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - Beta opcodes, ALU function selects, special instruction words and decode helpers
package beta_pkg;

  localparam logic [5:0] OP_LD    = 6'b011000;
  localparam logic [5:0] OP_ST    = 6'b011001;
  localparam logic [5:0] OP_JMP   = 6'b011011;
  localparam logic [5:0] OP_BEQ   = 6'b011100;
  localparam logic [5:0] OP_BNE   = 6'b011101;
  localparam logic [5:0] OP_LDR   = 6'b011111;
  localparam logic [5:0] OP_MUL   = 6'b100010;
  localparam logic [5:0] OP_MULC  = 6'b110010;

  localparam logic [1:0] ALU_MUX_ARITH = 2'b00;
  localparam logic [1:0] ALU_MUX_BOOL  = 2'b01;
  localparam logic [1:0] ALU_MUX_SHIFT = 2'b10;
  localparam logic [1:0] ALU_MUX_CMP   = 2'b11;

  // ADD(R31,R31,R31) and BNE(R31,0,XP)
  localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
  localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;

  typedef enum logic [1:0] {IDLE, HOLD, MUL} exec_state_t;
  typedef enum logic [1:0] {Y_ALU, Y_LINK, Y_MUL} y_sel_t;

  // Register and constant forms (10xxxx / 11xxxx) share the low four opcode bits.
  function automatic logic op_legal(input logic [5:0] op, input logic mul_en);
    logic ok;
    ok = 1'b0;
    if (op[5]) begin
      case (op[3:0])
        4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
        4'b1000, 4'b1001, 4'b1010, 4'b1011,
        4'b1100, 4'b1101, 4'b1110: ok = 1'b1;
        4'b0010:                   ok = mul_en;
        default:                   ok = 1'b0;
      endcase
    end else begin
      case (op)
        OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR: ok = 1'b1;
        default:                                      ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Bool selects are truth tables indexed by {a,b}; 1010 passes b through.
  function automatic logic [5:0] alu_fn(input logic [5:0] op);
    logic [5:0] fn;
    fn = {ALU_MUX_ARITH, 4'b0000};
    if (op[5]) begin
      case (op[3:0])
        4'b0001: fn = {ALU_MUX_ARITH, 4'b0001};
        4'b0100: fn = {ALU_MUX_CMP,   4'b0001};
        4'b0101: fn = {ALU_MUX_CMP,   4'b0010};
        4'b0110: fn = {ALU_MUX_CMP,   4'b0011};
        4'b1000: fn = {ALU_MUX_BOOL,  4'b1000};
        4'b1001: fn = {ALU_MUX_BOOL,  4'b1110};
        4'b1010: fn = {ALU_MUX_BOOL,  4'b0110};
        4'b1011: fn = {ALU_MUX_BOOL,  4'b1001};
        4'b1100: fn = {ALU_MUX_SHIFT, 4'b0000};
        4'b1101: fn = {ALU_MUX_SHIFT, 4'b0001};
        4'b1110: fn = {ALU_MUX_SHIFT, 4'b0011};
        default: fn = {ALU_MUX_ARITH, 4'b0000};
      endcase
    end else if (op == OP_LDR) begin
      fn = {ALU_MUX_BOOL, 4'b1010};
    end
    return fn;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - Combinational Beta ALU: arithmetic, compare, boolean truth table and shifts
module alu
  import beta_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  logic [3:0]    tt;
  logic          eq;
  logic          lt;

  assign sh = b[SW-1:0];
  assign tt = fn[3:0];
  assign eq = (a == b);
  assign lt = ($signed(a) < $signed(b));

  always_comb begin
    y = '0;
    case (fn[5:4])
      ALU_MUX_ARITH: y = fn[0] ? (a - b) : (a + b);
      ALU_MUX_BOOL: begin
        for (int i = 0; i < XLEN; i++) y[i] = tt[{a[i], b[i]}];
      end
      ALU_MUX_SHIFT: begin
        case (fn[1:0])
          2'b00:   y = a << sh;
          2'b01:   y = a >> sh;
          default: y = $signed(a) >>> sh;
        endcase
      end
      default: begin
        case (fn[1:0])
          2'b01:   y = {{(XLEN-1){1'b0}}, eq};
          2'b10:   y = {{(XLEN-1){1'b0}}, lt};
          2'b11:   y = {{(XLEN-1){1'b0}}, lt | eq};
          default: y = '0;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - Iterative shift-add multiplier, MUL_STEP_BITS multiplier bits per cycle, low XLEN bits kept
module mul_iter #(
  parameter int XLEN          = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int STEPS = XLEN / MUL_STEP_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] partial;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP_BITS; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      cnt_q    <= CW'(STEPS);
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      acc_q    <= acc_q + partial;
      mcand_q  <= mcand_q << MUL_STEP_BITS;
      mplier_q <= mplier_q >> MUL_STEP_BITS;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  assign done   = (cnt_q == '0);
  assign result = acc_q;
endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - Beta execute stage: one-slot valid/ready, ALU decode, exceptions, class flags
// Optional feature macro: EXECUTE_MUL_EN enables the iterative MUL/MULC path.
module execute_pipe
  import beta_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            exc_in,
  input  logic            flush,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] d,
  input  logic [31:0]     ir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] d_next,
  output logic [31:0]     ir_next,
  output logic [XLEN-1:0] y_next,
  output logic            op_ld_or_ldr,
  output logic            op_st,
  output logic            op_br_or_jmp,
  output logic            busy
);
`ifdef EXECUTE_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  exec_state_t     state_q, state_d;
  logic [XLEN-1:0] pc_q, a_q, b_q, d_q;
  logic [31:0]     ir_q;
  logic [5:0]      fn_q;
  y_sel_t          ysel_q;
  logic            ld_q, st_q, br_q;

  logic [5:0]      opcode;
  logic            legal, keep, is_mul_op, capture, start_mul, mul_done;
  logic [31:0]     cap_ir;
  logic            cap_ld, cap_st, cap_br;
  y_sel_t          cap_ysel;
  logic [XLEN-1:0] alu_y, mul_y;

  assign opcode    = ir[31:26];
  assign legal     = op_legal(opcode, MUL_EN);
  assign is_mul_op = (opcode == OP_MUL) || (opcode == OP_MULC);
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign capture   = in_valid && in_ready;
  assign start_mul = capture && is_mul_op && legal && !exc_in;

  // Excepted and illegal instructions carry no class flags; y becomes the link pc.
  always_comb begin
    keep   = legal && !exc_in;
    cap_ir = exc_in ? INST_NOP : (legal ? ir : INST_BNE_EXCEPT);
    cap_ld = keep && ((opcode == OP_LD) || (opcode == OP_LDR));
    cap_st = keep && (opcode == OP_ST);
    cap_br = keep && ((opcode == OP_JMP) || (opcode == OP_BEQ) || (opcode == OP_BNE));
    if (!keep || cap_br)  cap_ysel = Y_LINK;
    else if (is_mul_op)   cap_ysel = Y_MUL;
    else                  cap_ysel = Y_ALU;
  end

  // A capture replaces the slot even under flush; flush otherwise empties it.
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = start_mul ? MUL : HOLD;
    end else if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        HOLD:    if (out_ready) state_d = IDLE;
        MUL:     if (mul_done)  state_d = HOLD;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      ir_q    <= INST_NOP;
      fn_q    <= '0;
      ysel_q  <= Y_ALU;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        pc_q   <= pc;
        a_q    <= a;
        b_q    <= b;
        d_q    <= d;
        ir_q   <= cap_ir;
        fn_q   <= alu_fn(opcode);
        ysel_q <= cap_ysel;
        ld_q   <= cap_ld;
        st_q   <= cap_st;
        br_q   <= cap_br;
      end
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .fn (fn_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

`ifdef EXECUTE_MUL_EN
  mul_iter #(.XLEN(XLEN), .MUL_STEP_BITS(MUL_STEP_BITS)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (start_mul),
    .abort  (flush),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .result (mul_y)
  );
  assign busy = (state_q == MUL);
`else
  assign mul_done = 1'b0;
  assign mul_y    = '0;
  assign busy     = 1'b0;
`endif

  assign out_valid    = (state_q == HOLD);
  assign pc_next      = pc_q;
  assign d_next       = d_q;
  assign ir_next      = ir_q;
  assign op_ld_or_ldr = ld_q && out_valid;
  assign op_st        = st_q && out_valid;
  assign op_br_or_jmp = br_q && out_valid;

  always_comb begin
    case (ysel_q)
      Y_LINK:  y_next = pc_q;
      Y_MUL:   y_next = mul_y;
      default: y_next = alu_y;
    endcase
  end
endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - Self-checking bench for execute_pipe: directed cases plus randomized traffic against a reference model
module tb_execute_pipe;

  localparam logic [31:0] NOP_W = 32'h83FF_F800;
  localparam logic [31:0] EXC_W = 32'h77DF_0000;
`ifdef EXECUTE_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif

  logic        clk, rst, in_valid, in_ready, exc_in, flush, out_valid, out_ready;
  logic [31:0] pc, a, b, d, ir, pc_next, d_next, ir_next, y_next;
  logic        op_ld_or_ldr, op_st, op_br_or_jmp, busy;

  execute_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .exc_in(exc_in),
    .flush(flush), .pc(pc), .a(a), .b(b), .d(d), .ir(ir), .out_valid(out_valid),
    .out_ready(out_ready), .pc_next(pc_next), .d_next(d_next), .ir_next(ir_next),
    .y_next(y_next), .op_ld_or_ldr(op_ld_or_ldr), .op_st(op_st),
    .op_br_or_jmp(op_br_or_jmp), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] ir, y, pc, d;
    bit          ycheck, ld, st, br;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   armed = 0;
  bit   after_rst = 0;
  bit   ev;

  // Expected retirement of one instruction, from the opcode table and plain arithmetic.
  function automatic exp_t predict(input logic [31:0] i_ir, input logic [31:0] i_pc,
                                   input logic [31:0] i_a, input logic [31:0] i_b,
                                   input logic [31:0] i_d, input bit i_exc, input int now);
    exp_t e;
    logic [5:0] op;
    bit illegal;
    op = i_ir[31:26];
    e.ir = i_ir; e.pc = i_pc; e.d = i_d; e.y = 32'h0;
    e.ycheck = 1; e.ld = 0; e.st = 0; e.br = 0; e.rdy = now + 1;
    illegal = 0;
    case (op)
      6'h18:        begin e.y = i_a + i_b; e.ld = 1; end
      6'h19:        begin e.y = i_a + i_b; e.st = 1; end
      6'h1B, 6'h1C, 6'h1D: begin e.br = 1; e.ycheck = 0; end
      6'h1F:        begin e.y = i_b; e.ld = 1; end
      6'h20, 6'h30: e.y = i_a + i_b;
      6'h21, 6'h31: e.y = i_a - i_b;
      6'h22, 6'h32: begin
        if (MUL_LAT > 1) begin e.y = i_a * i_b; e.rdy = now + MUL_LAT; end
        else illegal = 1;
      end
      6'h24, 6'h34: e.y = (i_a == i_b) ? 32'd1 : 32'd0;
      6'h25, 6'h35: e.y = ($signed(i_a) <  $signed(i_b)) ? 32'd1 : 32'd0;
      6'h26, 6'h36: e.y = ($signed(i_a) <= $signed(i_b)) ? 32'd1 : 32'd0;
      6'h28, 6'h38: e.y = i_a & i_b;
      6'h29, 6'h39: e.y = i_a | i_b;
      6'h2A, 6'h3A: e.y = i_a ^ i_b;
      6'h2B, 6'h3B: e.y = ~(i_a ^ i_b);
      6'h2C, 6'h3C: e.y = i_a << i_b[4:0];
      6'h2D, 6'h3D: e.y = i_a >> i_b[4:0];
      6'h2E, 6'h3E: e.y = $signed(i_a) >>> i_b[4:0];
      default:      illegal = 1;
    endcase
    if (i_exc || illegal) begin
      e.ir = i_exc ? NOP_W : EXC_W;
      e.ycheck = 0; e.ld = 0; e.st = 0; e.br = 0; e.rdy = now + 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      ev = (q.size() > 0) && (cyc >= q[0].rdy);
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("m_busy", {31'b0, busy}, {31'b0, (q.size() > 0) && (cyc < q[0].rdy)});
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, (q.size() == 0) || (ev && out_ready)});
      if (ev) begin
        chk("m_ir_next", ir_next, q[0].ir);
        chk("m_pc_next", pc_next, q[0].pc);
        chk("m_d_next", d_next, q[0].d);
        chk("m_flags", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp},
            {29'b0, q[0].ld, q[0].st, q[0].br});
        if (q[0].ycheck) chk("m_y_next", y_next, q[0].y);
      end else begin
        chk("m_flags_idle", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, 32'h0);
      end
      if (after_rst) chk("m_ir_after_rst", ir_next, NOP_W);
      after_rst = 0;
    end
    if (rst) begin
      q.delete();
      after_rst = armed;
      armed = 1;
    end else if (armed) begin
      if ((q.size() > 0) && (flush || (ev && out_ready))) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(predict(ir, pc, a, b, d, exc_in, cyc));
    end
    cyc++;
  end

  function automatic logic [31:0] mk_ir(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h0000};
  endfunction

  task automatic drive(input bit v, input logic [5:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input bit exc, input bit fl, input bit ordy);
    @(posedge clk);
    #1;
    in_valid = v; ir = mk_ir(op); a = av; b = bv; exc_in = exc; flush = fl;
    out_ready = ordy; pc = $urandom; d = $urandom;
  endtask

  task automatic idle(input bit ordy);
    drive(0, 6'h20, 0, 0, 0, 0, ordy);
  endtask

  logic [5:0] op_tab [28] = '{6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F, 6'h20, 6'h21,
                             6'h22, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B,
                             6'h2C, 6'h2D, 6'h2E, 6'h30, 6'h31, 6'h32, 6'h35, 6'h3A,
                             6'h3E, 6'h00, 6'h23, 6'h3F};

  initial begin
    #200000;
    $display("FAIL watchdog expired n_total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit got, inr_ok, busy_ok, seen;
    rst = 1; in_valid = 0; exc_in = 0; flush = 0; out_ready = 1;
    pc = 0; a = 0; b = 0; d = 0; ir = NOP_W;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ir_next", ir_next, 32'h83FF_F800);
    chk("rst_pc_next", pc_next, 32'h0);

    // back-to-back ADD then SUB
    drive(1, 6'h20, 5, 7, 0, 0, 1); @(negedge clk);
    drive(1, 6'h21, 3, 5, 0, 0, 1); @(negedge clk);
    chk("t1_add_y", y_next, 32'd12);
    chk("t1_add_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_add_ir", ir_next, 32'h8022_0000);
    chk("t1_in_ready", {31'b0, in_ready}, 32'h1);
    idle(1); @(negedge clk);
    chk("t1_sub_y", y_next, 32'hFFFF_FFFE);
    chk("t1_sub_valid", {31'b0, out_valid}, 32'h1);
    idle(1); @(negedge clk);
    chk("t1_drained", {31'b0, out_valid}, 32'h0);

    // downstream stall for three cycles
    drive(1, 6'h20, 1, 2, 0, 0, 1); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'h20, 10, 20, 0, 0, 0); @(negedge clk);
      chk("t2_stall_y", y_next, 32'd3);
      chk("t2_stall_in_ready", {31'b0, in_ready}, 32'h0);
    end
    drive(1, 6'h20, 10, 20, 0, 0, 1); @(negedge clk);
    chk("t2_release_in_ready", {31'b0, in_ready}, 32'h1);
    idle(1); @(negedge clk);
    chk("t2_next_y", y_next, 32'd30);
    idle(1); @(negedge clk);

`ifdef EXECUTE_MUL_EN
    // multiply latency and result
    drive(1, 6'h22, 32'h0001_0001, 32'h0001_0001, 0, 0, 1); @(negedge clk);
    k = 0; got = 0; inr_ok = 1; busy_ok = 1;
    while (k < 100 && !got) begin
      drive(1, 6'h20, 1, 1, 0, 0, 1); @(negedge clk);
      k++;
      if (out_valid) got = 1;
      else begin
        if (in_ready) inr_ok = 0;
        if (!busy) busy_ok = 0;
      end
    end
    chk("t3_latency", k, 32'd33);
    chk("t3_mul_y", y_next, 32'h0002_0001);
    chk("t3_in_ready_low", {31'b0, inr_ok}, 32'h1);
    chk("t3_busy_high", {31'b0, busy_ok}, 32'h1);
    idle(1); @(negedge clk);
    chk("t3_after_add", y_next, 32'd2);
    idle(1); @(negedge clk);

    // flush aborts a running multiply
    drive(1, 6'h22, 7, 9, 0, 0, 1); @(negedge clk);
    repeat (9) begin idle(1); @(negedge clk); end
    drive(0, 6'h20, 0, 0, 0, 1, 1); @(negedge clk);
    idle(1); @(negedge clk);
    chk("t4_flush_valid", {31'b0, out_valid}, 32'h0);
    chk("t4_flush_busy", {31'b0, busy}, 32'h0);
    seen = 0;
    repeat (40) begin idle(1); @(negedge clk); if (out_valid) seen = 1; end
    chk("t4_no_result", {31'b0, seen}, 32'h0);
    drive(1, 6'h20, 2, 3, 0, 0, 1); @(negedge clk);
    idle(1); @(negedge clk);
    chk("t4_add_y", y_next, 32'd5);

    // reset in the middle of a multiply
    drive(1, 6'h22, 3, 3, 0, 0, 1); @(negedge clk);
    repeat (5) begin idle(1); @(negedge clk); end
    idle(1); rst = 1; @(negedge clk);
    idle(1); rst = 0; @(negedge clk);
    chk("t6_mul_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_mul_rst_busy", {31'b0, busy}, 32'h0);
    chk("t6_mul_rst_ir", ir_next, 32'h83FF_F800);
`else
    drive(1, 6'h22, 3, 3, 0, 0, 1); @(negedge clk);
    idle(1); @(negedge clk);
    chk("t3_mul_illegal_ir", ir_next, 32'h77DF_0000);
    chk("t3_mul_illegal_busy", {31'b0, busy}, 32'h0);
    chk("t3_mul_illegal_valid", {31'b0, out_valid}, 32'h1);
`endif

    // flush of a held result, and flush with same-cycle capture
    drive(1, 6'h20, 4, 4, 0, 0, 0); @(negedge clk);
    drive(0, 6'h20, 0, 0, 0, 1, 0); @(negedge clk);
    chk("t4_hold_y", y_next, 32'd8);
    idle(0); @(negedge clk);
    chk("t4_hold_flushed", {31'b0, out_valid}, 32'h0);
    drive(1, 6'h20, 1, 1, 0, 0, 1); @(negedge clk);
    drive(1, 6'h21, 9, 4, 0, 1, 1); @(negedge clk);
    idle(1); @(negedge clk);
    chk("t4_flush_capture_y", y_next, 32'd5);
    chk("t4_flush_capture_valid", {31'b0, out_valid}, 32'h1);

    // illegal opcode and upstream exception
    drive(1, 6'h00, 1, 1, 0, 0, 1); @(negedge clk);
    drive(1, 6'h00, 1, 1, 1, 0, 1); @(negedge clk);
    chk("t5_illegal_ir", ir_next, 32'h77DF_0000);
    chk("t5_illegal_flags", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, 32'h0);
    drive(1, 6'h18, 32'h100, 32'h20, 1, 0, 1); @(negedge clk);
    chk("t5_exc_ir", ir_next, 32'h83FF_F800);
    drive(1, 6'h18, 32'h100, 32'h20, 0, 0, 1); @(negedge clk);
    chk("t5_exc_ld_flags", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, 32'h0);
    idle(1); @(negedge clk);
    chk("t5_ld_flag", {31'b0, op_ld_or_ldr}, 32'h1);
    chk("t5_ld_y", y_next, 32'h120);

    // reset while holding a result
    drive(1, 6'h18, 5, 6, 0, 0, 0); @(negedge clk);
    idle(0); @(negedge clk);
    chk("t6_hold_ld_flag", {31'b0, op_ld_or_ldr}, 32'h1);
    idle(0); rst = 1; @(negedge clk);
    idle(1); rst = 0; @(negedge clk);
    chk("t6_hold_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_hold_rst_ir", ir_next, 32'h83FF_F800);
    chk("t6_hold_rst_flags", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, 32'h0);
    chk("t6_hold_rst_busy", {31'b0, busy}, 32'h0);

    // randomized traffic, checked by the model process
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      ir        = {op_tab[$urandom_range(0, 27)], 26'($urandom)};
      a         = $urandom;
      b         = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exc_in    = ($urandom_range(0, 15) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      pc        = $urandom;
      d         = $urandom;
    end
    @(posedge clk);
    #1 rst = 0;
    repeat (40) begin idle(1); @(negedge clk); end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
